// File: rtl/img_mem_pkg.sv
// Shared types for the image-ROM read-port scheduler.
//   state_e : scheduler mode (normal arbitration, copy sweep, post-copy)
//   tag_e   : owner of an issued ROM slot; the returned word is steered by it
package img_mem_pkg;

  localparam int unsigned IMG_ADDR_W = 15;
  localparam int unsigned IMG_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_COPY,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_DISP,
    TAG_DEC,
    TAG_COPY
  } tag_e;

endpackage

// File: rtl/img_tag_pipe.sv
// DEPTH-deep shift register carrying {tag, addr} alongside a memory access so
// the returned data can be steered to its owner.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   in_tag, in_addr   : slot issued this cycle
//   tag_q             : tag of every stage (stage DEPTH-1 is the returning one)
//   out_addr          : address of the returning slot
module img_tag_pipe
  import img_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = IMG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  tag_e              in_tag,
  input  logic [ADDR_W-1:0] in_addr,
  output tag_e              tag_q [DEPTH],
  output logic [ADDR_W-1:0] out_addr
);

  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= TAG_NONE;
        addr_q[i] <= '0;
      end
    end else begin
      tag_q[0]  <= in_tag;
      addr_q[0] <= in_addr;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        tag_q[i]  <= tag_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/img_mem_scheduler.sv
// Shares the single read port of the encrypted-image ROM between the VGA
// sprite fetch (priority) and the decrypter (background, starvation-bounded),
// then, once the decrypter is done, sweeps every ROM word into the
// decryption buffer write port.
// Ports:
//   clk, rst                      : pixel clock, asynchronous active-low reset
//   disp_req/addr -> valid/data   : display read channel
//   dec_req/addr -> gnt/valid/data: decrypter read channel
//   dec_done                      : decrypter finished, starts the copy sweep
//   mem_addr, mem_dout            : ROM read port (address registered here)
//   wr_en/addr/data               : decryption buffer write port
//   copy_busy, copy_done          : sweep status (copy_done sticky until reset)
module img_mem_scheduler
  import img_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = IMG_ADDR_W,
  parameter int unsigned DATA_W     = IMG_DATA_W,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned IMG_WORDS  = 25600,
  parameter int unsigned STARVE_MAX = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              dec_req,
  input  logic [ADDR_W-1:0] dec_addr,
  output logic              dec_gnt,
  output logic              dec_valid,
  output logic [DATA_W-1:0] dec_data,
  input  logic              dec_done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              copy_busy,
  output logic              copy_done
);

  localparam int unsigned     L          = 1 + RD_LAT;
  localparam int unsigned     SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [ADDR_W:0] CNT_END    = (ADDR_W+1)'(IMG_WORDS);

  state_e            state, state_nxt;
  tag_e              sel_tag;
  logic [ADDR_W-1:0] sel_addr;
  tag_e              pipe_tag [L];
  tag_e              ret_tag;
  logic [ADDR_W-1:0] ret_addr;
  logic              pipe_busy;
  logic              dec_win;
  logic [ADDR_W:0]   cnt;
  logic [SW-1:0]     starve;
  logic [DATA_W-1:0] disp_hold, dec_hold;

  img_tag_pipe #(
    .DEPTH (L),
    .ADDR_W(ADDR_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_tag  (sel_tag),
    .in_addr (sel_addr),
    .tag_q   (pipe_tag),
    .out_addr(ret_addr)
  );

  assign ret_tag = pipe_tag[L-1];

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i < L; i++) begin
      if (pipe_tag[i] != TAG_NONE) pipe_busy = 1'b1;
    end
  end

  // One slot per cycle. While dec_done is high in RUN no new slot is issued;
  // the pipe drains (so an in-flight dec grant still returns) and only then
  // the sweep starts, keeping COPY free of display/decrypter returns.
  always_comb begin
    sel_tag   = TAG_NONE;
    sel_addr  = mem_addr;
    state_nxt = state;
    dec_win   = dec_req && (!disp_req || starve == STARVE_LIM);
    case (state)
      ST_RUN: begin
        if (dec_done) begin
          if (!pipe_busy) state_nxt = ST_COPY;
        end else if (dec_win) begin
          sel_tag  = TAG_DEC;
          sel_addr = dec_addr;
        end else if (disp_req) begin
          sel_tag  = TAG_DISP;
          sel_addr = disp_addr;
        end
      end
      ST_COPY: begin
        if (cnt != CNT_END) begin
          sel_tag  = TAG_COPY;
          sel_addr = cnt[ADDR_W-1:0];
        end else if (!pipe_busy) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (disp_req) begin
          sel_tag  = TAG_DISP;
          sel_addr = disp_addr;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      mem_addr  <= '0;
      dec_gnt   <= 1'b0;
      starve    <= '0;
      cnt       <= '0;
      disp_hold <= '0;
      dec_hold  <= '0;
    end else begin
      state   <= state_nxt;
      dec_gnt <= (sel_tag == TAG_DEC);
      if (sel_tag != TAG_NONE) mem_addr <= sel_addr;

      if (state == ST_RUN && state_nxt == ST_COPY) cnt <= '0;
      else if (sel_tag == TAG_COPY) cnt <= cnt + (ADDR_W+1)'(1);

      // Counts consecutive display wins while the decrypter is waiting.
      if (sel_tag == TAG_DEC || !dec_req) starve <= '0;
      else if (sel_tag == TAG_DISP && starve != STARVE_LIM) starve <= starve + SW'(1);

      if (disp_valid) disp_hold <= mem_dout;
      if (dec_valid)  dec_hold  <= mem_dout;
    end
  end

  assign disp_valid = (ret_tag == TAG_DISP);
  assign dec_valid  = (ret_tag == TAG_DEC);
  assign wr_en      = (ret_tag == TAG_COPY);
  assign disp_data  = disp_valid ? mem_dout : disp_hold;
  assign dec_data   = dec_valid ? mem_dout : dec_hold;
  assign wr_addr    = wr_en ? ret_addr : '0;
  assign wr_data    = wr_en ? mem_dout : '0;
  assign copy_busy  = (state == ST_COPY);
  assign copy_done  = (state == ST_DONE);

endmodule

// File: tb/tb_img_mem_scheduler.sv
// Directed bench for img_mem_scheduler with a 1-cycle-latency ROM model.
module tb_img_mem_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req, dec_req, dec_done;
  logic [14:0] disp_addr, dec_addr;
  logic        disp_valid, dec_gnt, dec_valid;
  logic [7:0]  disp_data, dec_data;
  logic [14:0] mem_addr, wr_addr;
  logic [7:0]  mem_dout, wr_data;
  logic        wr_en, copy_busy, copy_done;

  int checks = 0;
  int errors = 0;

  img_mem_scheduler #(
    .ADDR_W    (15),
    .DATA_W    (8),
    .RD_LAT    (1),
    .IMG_WORDS (8),
    .STARVE_MAX(64)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_valid(disp_valid),
    .disp_data (disp_data),
    .dec_req   (dec_req),
    .dec_addr  (dec_addr),
    .dec_gnt   (dec_gnt),
    .dec_valid (dec_valid),
    .dec_data  (dec_data),
    .dec_done  (dec_done),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .copy_busy (copy_busy),
    .copy_done (copy_done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_word(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
  endfunction

  always @(posedge clk) mem_dout <= rom_word(mem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gnt_cnt, first_gnt, second_gnt, dv_cnt, decv_cnt, nw, bad_side;
    logic [7:0] last_dec;
    logic found;

    rst = 1'b0;
    disp_req = 1'b0; dec_req = 1'b0; dec_done = 1'b0;
    disp_addr = '0; dec_addr = '0;
    step(); step();
    check("rst_mem_addr",   mem_addr,   0);
    check("rst_disp_valid", disp_valid, 0);
    check("rst_disp_data",  disp_data,  0);
    check("rst_dec_gnt",    dec_gnt,    0);
    check("rst_wr_en",      wr_en,      0);
    check("rst_copy_busy",  copy_busy,  0);
    check("rst_copy_done",  copy_done,  0);
    rst = 1'b1;

    // display read, 2-cycle return
    disp_req = 1'b1; disp_addr = 15'd100;
    step();
    check("t1_mem_addr", mem_addr, 100);
    check("t1_valid_c1", disp_valid, 0);
    check("t1_gnt_c1", dec_gnt, 0);
    step();
    check("t1_disp_valid", disp_valid, 1);
    check("t1_disp_data", disp_data, rom_word(15'd100));
    check("t1_gnt_c2", dec_gnt, 0);
    disp_req = 1'b0;
    step(); step();
    check("t1_valid_low", disp_valid, 0);
    check("t1_data_hold", disp_data, rom_word(15'd100));
    check("t1_addr_hold", mem_addr, 100);

    // decrypter read
    dec_req = 1'b1; dec_addr = 15'h1234;
    step();
    check("t2_gnt", dec_gnt, 1);
    dec_req = 1'b0;
    step();
    check("t2_gnt_pulse", dec_gnt, 0);
    check("t2_dec_valid", dec_valid, 1);
    check("t2_dec_data", dec_data, rom_word(15'h1234));
    step();
    check("t2_valid_low", dec_valid, 0);
    check("t2_data_hold", dec_data, rom_word(15'h1234));

    // both requesters held: decrypter forced in every 65th slot
    disp_addr = 15'd200; dec_addr = 15'h0300;
    disp_req = 1'b1; dec_req = 1'b1;
    gnt_cnt = 0; first_gnt = 0; second_gnt = 0; dv_cnt = 0; decv_cnt = 0; last_dec = '0;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (dec_gnt) begin
        gnt_cnt++;
        if (gnt_cnt == 1) first_gnt = n;
        else if (gnt_cnt == 2) second_gnt = n;
      end
      if (disp_valid) dv_cnt++;
      if (dec_valid) begin
        decv_cnt++;
        last_dec = dec_data;
      end
    end
    check("t3_first_gnt", first_gnt, 65);
    check("t3_gnt_period", second_gnt - first_gnt, 65);
    check("t3_gnt_count", gnt_cnt, 3);
    check("t3_disp_count", dv_cnt, 196);
    check("t3_dec_count", decv_cnt, 3);
    check("t3_dec_data", last_dec, rom_word(15'h0300));
    disp_req = 1'b0; dec_req = 1'b0;
    step(); step(); step();

    // dec_done raised as the grant pulses: return first, then the sweep
    dec_req = 1'b1; dec_addr = 15'h0042;
    step();
    check("t5_gnt", dec_gnt, 1);
    dec_req = 1'b0; dec_done = 1'b1;
    step();
    check("t5_dec_valid", dec_valid, 1);
    check("t5_dec_data", dec_data, rom_word(15'h0042));
    check("t5_no_wr_c2", wr_en, 0);
    check("t5_busy_c2", copy_busy, 0);
    step();
    check("t5_busy_c3", copy_busy, 0);
    check("t5_no_wr_c3", wr_en, 0);
    step();
    check("t5_copy_entry", copy_busy, 1);
    disp_req = 1'b1; disp_addr = 15'd5; dec_req = 1'b1; dec_addr = 15'h0011;
    dec_done = 1'b0;
    nw = 0; bad_side = 0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (wr_en) begin
        check("t5_wr_addr", wr_addr, nw);
        check("t5_wr_data", wr_data, rom_word(15'(nw)));
        nw++;
      end
      if (disp_valid || dec_gnt || dec_valid) bad_side++;
      if (copy_done) break;
    end
    check("t5_wr_count", nw, 8);
    check("t5_side_traffic", bad_side, 0);
    check("t5_copy_done", copy_done, 1);
    check("t5_busy_clear", copy_busy, 0);
    step();
    check("t5_done_no_gnt1", dec_gnt, 0);
    step();
    check("t5_done_disp_valid", disp_valid, 1);
    check("t5_done_disp_data", disp_data, rom_word(15'd5));
    check("t5_done_no_gnt2", dec_gnt, 0);
    check("t5_done_sticky", copy_done, 1);

    // reset in the middle of a sweep
    disp_req = 1'b0; dec_req = 1'b0;
    rst = 1'b0;
    step();
    check("t6_rst_done", copy_done, 0);
    rst = 1'b1; dec_done = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (wr_en && wr_addr == 15'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("t6_wr3_seen", found, 1);
    rst = 1'b0;
    #1;
    check("t6_abort_wr_en", wr_en, 0);
    check("t6_abort_wr_addr", wr_addr, 0);
    check("t6_abort_wr_data", wr_data, 0);
    check("t6_abort_busy", copy_busy, 0);
    check("t6_abort_mem_addr", mem_addr, 0);
    dec_done = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("t6_run_busy", copy_busy, 0);
    check("t6_run_done", copy_done, 0);
    dec_req = 1'b1; dec_addr = 15'd7;
    step();
    check("t6_run_gnt", dec_gnt, 1);
    dec_req = 1'b0;
    step();
    check("t6_run_dec_data", dec_data, rom_word(15'd7));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/img_mem_scheduler.md
Name: img_mem_scheduler

Overview:
- Owns the single read port of the encrypted-image ROM (8-bit words, 15-bit address) and shares it between two requesters: the VGA sprite fetch, which is latency-critical, and the decrypter, which runs in the background.
- When the decrypter signals completion, it runs a copy sweep that streams every ROM word into the decryption buffer's write port.
- It replaces the ad-hoc address muxing and the hand-tuned write-address offset in the display top level.
- Sits between vga_bsprite, decrypter, the image ROM and decryption_mem, all in the 25 MHz pixel clock domain.

Parameters:
- ADDR_W, 15, address width of ROM and buffer
- DATA_W, 8, word width
- RD_LAT, 1, ROM read latency in cycles (address registered to data valid)
- IMG_WORDS, 25600, number of words swept by the copy (legal range 1..2^ADDR_W)
- STARVE_MAX, 64, consecutive display-won cycles with decrypter waiting before the decrypter is forced a slot

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- disp_req  in  1  display wants a word this cycle (inside_image & ~blank)
- disp_addr  in  ADDR_W  display read address
- disp_valid  out  1  disp_data valid
- disp_data  out  DATA_W  returned display word
- dec_req  in  1  decrypter read request; held with dec_addr stable until granted
- dec_addr  in  ADDR_W  decrypter read address
- dec_gnt  out  1  one-cycle pulse: request accepted
- dec_valid  out  1  dec_data valid
- dec_data  out  DATA_W  returned decrypter word
- dec_done  in  1  decrypter finished (level)
- mem_addr  out  ADDR_W  ROM address, registered
- mem_dout  in  DATA_W  ROM data
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  buffer write address
- wr_data  out  DATA_W  buffer write data
- copy_busy  out  1  copy sweep in progress
- copy_done  out  1  copy complete; sticky until reset

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to RUN.
  - All outputs clear to 0, including mem_addr.
  - Starvation counter and tag pipeline clear.
  - Reset asserted mid-copy aborts the copy; no partial-state recovery.
- Latency:
  - An access selected in cycle t drives mem_addr at t+1.
  - Data returns on the matching *_valid/*_data in cycle t+1+RD_LAT, so L = 1+RD_LAT.
  - Each issued slot carries a tag {none, disp, dec, copy, addr} through an L-deep pipeline; the tag alone steers the returned data.
  - *_data equals mem_dout when the matching valid is high, and holds its last value otherwise.
- RUN state arbitration (one grant per cycle):
  - disp_req=1 and starve<STARVE_MAX: display wins. starve increments if dec_req=1, saturating.
  - dec_req=1 and (disp_req=0 or starve==STARVE_MAX): decrypter wins. dec_gnt pulses in cycle t+1 and starve clears.
  - Both low: idle slot. mem_addr holds its value and the tag is none.
  - The decrypter sees dec_gnt at t+1. It may present a new request at t+1; the same request is never granted twice.
- RUN to COPY transition:
  - Taken when dec_done=1 and no dec tag is in flight; a pending un-granted dec_req is dropped.
  - On entry, copy counter a=0 and copy_busy=1.
- COPY state:
  - Issues a = 0..IMG_WORDS-1, one per cycle, with no gaps.
  - Each returned copy tag produces wr_en=1, wr_addr = tagged address, wr_data = mem_dout, so the write address is exactly aligned with its data.
  - disp_valid and dec_gnt stay 0; requests are ignored and not queued.
  - dec_done falling during COPY is ignored.
- COPY to DONE transition:
  - Taken after the last copy tag retires, i.e. the write of address IMG_WORDS-1.
  - At that point copy_busy=0 and copy_done=1.
- DONE state:
  - Display is served as in RUN, with the same latency.
  - dec_req is never granted.
  - Remains in DONE until reset.
- Address arithmetic: the copy counter is ADDR_W+1 bits wide, so IMG_WORDS=2^ADDR_W terminates without wrapping.
- Simultaneous events: dec_done rising in the same cycle a dec grant is issued delays the COPY entry until that grant's data returns.

Decomposition:
- Shared package img_mem_pkg holds:
  - state enum RUN/COPY/DONE
  - tag enum NONE/DISP/DEC/COPY
  - ADDR_W and DATA_W defaults
- One sub-module: img_tag_pipe, a parameterised L-deep shift register carrying {tag, addr}. It is reused later for the write-port scheduler.

Test Plan:
- Reset then disp_req held with disp_addr=100: mem_addr=100 at cycle 1; disp_valid=1 with data = ROM[100] at cycle 2 (RD_LAT=1); dec_gnt=0 throughout.
- dec_req held with dec_addr=0x1234 and disp_req=0: dec_gnt pulses once the next cycle; dec_valid one cycle later with ROM[0x1234].
- disp_req and dec_req both held continuously: dec_gnt fires exactly once every STARVE_MAX+1 cycles (every 65th cycle); display starves only in that slot.
- IMG_WORDS=8, dec_done=1 asserted in RUN: copy_busy for the sweep; wr_en pulses 8 times with wr_addr 0..7 and wr_data = ROM[0..7] in order; then copy_done=1 and copy_busy=0.
- dec_done asserted in the cycle a dec grant is issued: the dec_valid return occurs first, then COPY begins; no wr_en before that return.
- rst pulled low when wr_addr=3 mid-copy: all outputs go to 0 immediately; after release the state is RUN and copy_done=0.
